mux_scan_ctrl: RTL

- Sequencer directly upstream of mux_4x1. It drives the mux's 2-bit select and samples the mux output.
- On each start it scans the enabled channels in ascending index order. It holds each select for a programmable dwell, then captures the mux output.
- It produces a 4-bit snapshot plus a one-cycle completion pulse. This is the first clocked block in the gate library and is used to poll four single-bit sources through one mux.

---
 rtl/mux_scan_pkg.sv | 17 +
 rtl/mux_scan_ctrl_next_ch_find.sv | 34 +++
 rtl/mux_scan_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux_4x1 scan sequencer: state encoding, channel
// geometry and reset values.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [SEL_W-1:0]  SEL_RST    = 2'b00;
  localparam logic [NUM_CH-1:0] SAMPLE_RST = 4'b0000;

endpackage

// File: rtl/mux_scan_ctrl_next_ch_find.sv
// Picks the next enabled channel: the lowest set mask bit when first=1,
// otherwise the lowest set bit strictly above cur.
module next_ch_find
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              first,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  logic [NUM_CH-1:0] elig_s;

  // Restrict the mask to candidates, then priority-encode from bit 0 upward.
  always_comb begin
    elig_s = 4'b0000;
    nxt    = 2'b00;
    found  = 1'b0;
    if (first) begin
      elig_s = mask;
    end else begin
      elig_s = mask & (4'b1110 << cur);
    end
    casez (elig_s)
      4'b???1: begin nxt = 2'd0; found = 1'b1; end
      4'b??10: begin nxt = 2'd1; found = 1'b1; end
      4'b?100: begin nxt = 2'd2; found = 1'b1; end
      4'b1000: begin nxt = 2'd3; found = 1'b1; end
      default: begin nxt = 2'd0; found = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for mux_4x1: walks the enabled channels in ascending order,
// dwells on each, captures the mux output and reports a 4-bit snapshot.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         ch_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [1:0]         sel,
  output logic               busy,
  output logic               done,
  output logic [3:0]         sample,
  output logic               sample_valid
);

  state_t             state_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [NUM_CH-1:0]  mask_r;
  logic [SEL_W-1:0]   sel_r;
  logic [NUM_CH-1:0]  sample_r;
  logic               busy_r;
  logic               done_r;
  logic               valid_r;

  logic               is_idle_s;
  logic [NUM_CH-1:0]  find_mask_s;
  logic [SEL_W-1:0]   nxt_s;
  logic               found_s;

  // In IDLE the finder looks at the live mask for the first channel; during
  // SCAN it advances over the latched copy.
  always_comb begin
    is_idle_s = (state_r == IDLE);
    if (is_idle_s) begin
      find_mask_s = ch_en;
    end else begin
      find_mask_s = mask_r;
    end
  end

  next_ch_find u_next_ch_find (
    .mask  (find_mask_s),
    .cur   (sel_r),
    .first (is_idle_s),
    .nxt   (nxt_s),
    .found (found_s)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      dwell_r  <= '0;
      mask_r   <= 4'b0000;
      sel_r    <= SEL_RST;
      sample_r <= SAMPLE_RST;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sample_r <= SAMPLE_RST;
            if (ch_en != 4'b0000) begin
              mask_r  <= ch_en;
              dwell_r <= dwell;
              cnt_r   <= dwell;
              sel_r   <= nxt_s;
              valid_r <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= SCAN;
            end else begin
              done_r  <= 1'b1;
              valid_r <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - DWELL_W'(1);
          end else begin
            sample_r[sel_r] <= mux_out;
            if (found_s) begin
              sel_r <= nxt_s;
              cnt_r <= dwell_r;
            end else begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              valid_r <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign sel          = sel_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign sample       = sample_r;
  assign sample_valid = valid_r;

endmodule
